// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the chunked, elastic pipelined adder.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits added per stage; a zero stage count is guarded so elaboration can report it cleanly.
    function automatic int chunk_w(input int width, input int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline slot: adds its operand chunk with the upstream carry and holds the
// result, carry and operands until the downstream slot takes them.
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] a_up,
    input  logic [WIDTH-1:0] b_up,
    input  logic [WIDTH-1:0] sum_up,
    input  logic             c_up,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] a_dn,
    output logic [WIDTH-1:0] b_dn,
    output logic [WIDTH-1:0] sum_dn,
    output logic             c_dn,
    output logic             ovf_dn
);

    // Chunks at or below this stage are consumed; only the upper ones travel on.
    localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << ((IDX + 1) * CHUNK);

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   s;

    assign a_c      = a_up[IDX*CHUNK +: CHUNK];
    assign b_c      = b_up[IDX*CHUNK +: CHUNK];
    assign s        = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, c_up};
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            a_dn     <= '0;
            b_dn     <= '0;
            sum_dn   <= '0;
            c_dn     <= 1'b0;
            ovf_dn   <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                a_dn                       <= a_up & KEEP;
                b_dn                       <= b_up & KEEP;
                sum_dn                     <= sum_up;
                sum_dn[IDX*CHUNK +: CHUNK] <= s[CHUNK-1:0];
                c_dn                       <= s[CHUNK];
                // Only the top stage's flag is meaningful: it sees the operand and sum MSBs.
                ovf_dn                     <= (a_c[CHUNK-1] == b_c[CHUNK-1]) &&
                                              (s[CHUNK-1] != a_c[CHUNK-1]);
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Elastic ripple-by-chunk adder/subtractor: STAGES slots with valid/ready flow
// control, bubble collapsing and stall-stable outputs.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic [STAGES:0]            vld, rdy, cy;
    logic [STAGES:0][WIDTH-1:0] opa, opb, psum;
    logic [STAGES-1:0]          ov;
    logic                       unused_ops;

    // Subtraction is a + ~b + 1, so invert b and force the carry once, up front.
    assign vld[0]      = in_valid;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    assign opa[0]      = a;
    assign opb[0]      = (sub == OP_SUB) ? ~b : b;
    assign cy[0]       = (sub == OP_SUB) ? 1'b1 : cin;
    assign psum[0]     = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .a_up     (opa[k]),
            .b_up     (opb[k]),
            .sum_up   (psum[k]),
            .c_up     (cy[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .a_dn     (opa[k+1]),
            .b_dn     (opb[k+1]),
            .sum_dn   (psum[k+1]),
            .c_dn     (cy[k+1]),
            .ovf_dn   (ov[k])
        );
    end

    assign out_valid  = vld[STAGES];
    assign sum        = psum[STAGES];
    assign cout       = cy[STAGES];
    assign ovf        = ov[STAGES-1];
    assign unused_ops = ^{opa[STAGES], opb[STAGES], ov};

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; each stage adds WIDTH/STAGES bits (CHUNK).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  sum, cout and ovf are valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Elaboration SHALL fail if WIDTH % STAGES != 0 or STAGES < 1.
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-018 Subtract mode SHALL compute {cout,sum} = a + ~b + 1; cin is ignored.
REQ-019 ovf SHALL be 1 iff the MSBs of a and effective b are equal and differ from the sum MSB.
REQ-020 Stage k (0..STAGES-1) SHALL add chunk k of the operands with the carry registered by stage k-1, then register partial sum, carry and the remaining operand chunks.
REQ-021 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-023 Each stage holds one valid bit; a stage SHALL load when empty or when its contents move forward in the same cycle (bubble collapsing).
REQ-024 in_ready SHALL be combinational: stage 0 empty, or stage 0 advancing this cycle.
REQ-025 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-026 With out_ready = 0 the pipeline SHALL fill to STAGES entries, then drop in_ready; no entry lost, duplicated or reordered.
REQ-027 While out_valid = 1 and out_ready = 0, sum, cout and ovf SHALL stay stable.
REQ-028 Results SHALL emerge in acceptance order.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits and force out_valid, sum, cout, ovf to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight operands; no stale result appears after release.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 Package pipelined_adder_pkg SHALL hold OP_ADD = 1'b0, OP_SUB = 1'b1 and a helper function computing CHUNK.
REQ-033 One sub-module, adder_stage (CHUNK-bit add with registered carry, valid bit and stall control), SHALL be instantiated STAGES times via generate.

Verification (WIDTH=16, STAGES=4)
REQ-034 add a=0x1234 b=0x0FFF cin=1, out_ready=1 -> sum=0x2234 cout=0 ovf=0, out_valid 4 cycles after acceptance.
REQ-035 add a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 ovf=0 (carry crosses all stages); a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1.
REQ-036 sub a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1; sub a=0x0003 b=0x0005 -> sum=0xFFFE cout=0 ovf=0.
REQ-037 8 back-to-back inputs, out_ready=0 after the first output -> in_ready falls after 4 held entries and outputs stay stable; out_ready=1 -> all 8 results arrive in order, none missing.
REQ-038 rst_n pulsed low with 3 entries in flight -> out_valid=0 at once; after release no result appears until new input plus 4 cycles.
REQ-039 Random a, b, cin, sub with random out_ready over 1000 transactions -> every result matches a reference model.
